// File: rtl/rv32_decode_stage.sv
// RV32I (+ optional M) decode pipeline stage.
// The stage decodes one fetched instruction per cycle and holds the result in an
// output register. The register supports back-pressure and flush. Decode is
// purely combinational from in_inst, and every decoded field is captured on
// load. Illegal encodings still flow down the pipe with illegal=1 and all of
// their other fields cleared.
module rv32_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int ALU_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             rs1_en,
  output logic             rs2_en,
  output logic             rd_we,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [2:0]       fmt,
  output logic [XLEN-1:0]  imm,
  output logic             muldiv,
  output logic             illegal
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SYS = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Instruction fields
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_funct7 = in_inst[31:25];

  // Decode results, after illegal encodings have been masked
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_rd_used;
  fmt_e        w_fmt;
  logic [31:0] w_imm;
  logic [3:0]  w_alu4;
  logic        w_muldiv;
  logic        w_bad;

  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic             w_rd_we;
  logic [ALU_W-1:0] w_alu_ctrl;
  logic             w_load;

  // Classify the opcode, build the immediate and the ALU op, and flag illegal encodings.
  always_comb begin
    // NOTE: every signal gets a default before the case, so that no path through the block infers a latch.
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_rd_used  = 1'b0;
    w_fmt      = FMT_R;
    w_imm      = '0;
    w_alu4     = 4'd0;
    w_muldiv   = 1'b0;
    w_bad      = (in_inst[1:0] != 2'b11);

    case (w_opcode)
      OPC_OP: begin
        w_fmt      = FMT_R;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_rd_used  = 1'b1;
        if (w_funct7 == F7_BASE) begin
          w_alu4 = {1'b0, w_funct3};
        end else if (w_funct7 == F7_ALT) begin
          w_alu4 = {1'b1, w_funct3};
          if (w_funct3 != 3'b000 && w_funct3 != 3'b101) w_bad = 1'b1;
        end else if (w_funct7 == F7_MUL && ENABLE_M) begin
          w_alu4   = {1'b0, w_funct3};
          w_muldiv = 1'b1;
        end else begin
          w_bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_fmt      = FMT_I;
        w_rs1_used = 1'b1;
        w_rd_used  = 1'b1;
        w_imm      = {{20{in_inst[31]}}, in_inst[31:20]};
        // Only shift-right-immediate carries an arithmetic/logical select in inst[30].
        w_alu4     = {(w_funct3 == 3'b101) ? in_inst[30] : 1'b0, w_funct3};
        if (w_funct3 == 3'b001 && w_funct7 != F7_BASE) w_bad = 1'b1;
        if (w_funct3 == 3'b101 && w_funct7 != F7_BASE && w_funct7 != F7_ALT) w_bad = 1'b1;
      end
      OPC_LOAD, OPC_JALR: begin
        w_fmt      = FMT_I;
        w_rs1_used = 1'b1;
        w_rd_used  = 1'b1;
        w_imm      = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_STORE: begin
        w_fmt      = FMT_S;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OPC_BRANCH: begin
        w_fmt      = FMT_B;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        w_alu4     = {1'b0, w_funct3};
      end
      OPC_LUI, OPC_AUIPC: begin
        w_fmt     = FMT_U;
        w_rd_used = 1'b1;
        w_imm     = {in_inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        w_fmt     = FMT_J;
        w_rd_used = 1'b1;
        w_imm     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OPC_FENCE, OPC_SYSTEM: begin
        w_fmt = FMT_SYS;
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase

    // An illegal instruction still travels down the pipe, but it carries no side effects.
    if (w_bad) begin
      w_rs1_used = 1'b0;
      w_rs2_used = 1'b0;
      w_rd_used  = 1'b0;
      w_fmt      = FMT_R;
      w_imm      = '0;
      w_alu4     = 4'd0;
      w_muldiv   = 1'b0;
    end
  end

  // Drive unused index fields to zero, suppress writes to x0, and widen the ALU op.
  always_comb begin
    w_rs1      = w_rs1_used ? in_inst[19:15] : 5'd0;
    w_rs2      = w_rs2_used ? in_inst[24:20] : 5'd0;
    w_rd       = w_rd_used  ? in_inst[11:7]  : 5'd0;
    w_rd_we    = w_rd_used && (in_inst[11:7] != 5'd0);
    w_alu_ctrl = '0;
    w_alu_ctrl[3:0] = w_alu4;
  end

  // Handshake: the stage accepts when its register is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign w_load   = in_valid && in_ready && !flush;

  // Valid flag: flush wins, then load, then consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      // NOTE: state registers use non-blocking assignment, so that every flop samples pre-edge values.
      out_valid <= 1'b0;
    end else if (w_load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Decoded payload: captured only on an accepted load and otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pc   <= '0;
      rs1      <= '0;
      rs2      <= '0;
      rd       <= '0;
      rs1_en   <= 1'b0;
      rs2_en   <= 1'b0;
      rd_we    <= 1'b0;
      alu_ctrl <= '0;
      fmt      <= '0;
      imm      <= '0;
      muldiv   <= 1'b0;
      illegal  <= 1'b0;
    end else if (w_load) begin
      out_pc   <= in_pc;
      rs1      <= w_rs1;
      rs2      <= w_rs2;
      rd       <= w_rd;
      rs1_en   <= w_rs1_used;
      rs2_en   <= w_rs2_used;
      rd_we    <= w_rd_we;
      alu_ctrl <= w_alu_ctrl;
      fmt      <= w_fmt;
      imm      <= XLEN'($signed(w_imm));
      muldiv   <= w_muldiv;
      illegal  <= w_bad;
    end
  end

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage. It drives two instances that share
// their inputs: one with the M extension disabled and one with it enabled.
module tb_rv32_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, rs1_en, rs2_en, rd_we, muldiv, illegal;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_ctrl;
  logic [2:0]  fmt;

  logic        m1_in_ready, m1_out_valid, m1_rs1_en, m1_rs2_en, m1_rd_we, m1_muldiv, m1_illegal;
  logic [31:0] m1_out_pc, m1_imm;
  logic [4:0]  m1_rs1, m1_rs2, m1_rd;
  logic [3:0]  m1_alu_ctrl;
  logic [2:0]  m1_fmt;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ALU_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rd_we(rd_we), .alu_ctrl(alu_ctrl), .fmt(fmt), .imm(imm), .muldiv(muldiv),
    .illegal(illegal)
  );

  rv32_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ALU_W(4)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m1_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(m1_out_valid), .out_ready(out_ready),
    .out_pc(m1_out_pc), .rs1(m1_rs1), .rs2(m1_rs2), .rd(m1_rd), .rs1_en(m1_rs1_en),
    .rs2_en(m1_rs2_en), .rd_we(m1_rd_we), .alu_ctrl(m1_alu_ctrl), .fmt(m1_fmt),
    .imm(m1_imm), .muldiv(m1_muldiv), .illegal(m1_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle, then leave the input idle.
  task automatic decode_one(input logic [31:0] inst, input logic [31:0] pc);
    drive(1'b1, inst, pc);
    tick();
    drive(1'b0, 32'h0, 32'h0);
  endtask

  // Compare the full decoded bundle of the ENABLE_M=0 instance; en = {rs1_en, rs2_en, rd_we}.
  task automatic expect_dec(input string tag, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                            input logic [4:0] e_rd, input logic [2:0] e_en, input logic [3:0] e_alu,
                            input logic [2:0] e_fmt, input logic [31:0] e_imm, input logic e_ill);
    check($sformatf("%s.valid", tag), out_valid, 1'b1);
    check($sformatf("%s.rs1", tag), rs1, e_rs1);
    check($sformatf("%s.rs2", tag), rs2, e_rs2);
    check($sformatf("%s.rd", tag), rd, e_rd);
    check($sformatf("%s.en", tag), {rs1_en, rs2_en, rd_we}, e_en);
    check($sformatf("%s.alu", tag), alu_ctrl, e_alu);
    check($sformatf("%s.fmt", tag), fmt, e_fmt);
    check($sformatf("%s.imm", tag), imm, e_imm);
    check($sformatf("%s.illegal", tag), illegal, e_ill);
    check($sformatf("%s.muldiv", tag), muldiv, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    check("rst.valid", out_valid, 1'b0);
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.rd", rd, 5'd0);
    check("rst.imm", imm, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // add x3,x1,x2
    drive(1'b1, 32'h002081B3, 32'h100);
    check("add.in_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    expect_dec("add", 5'd1, 5'd2, 5'd3, 3'b111, 4'h0, 3'd0, 32'h0, 1'b0);
    check("add.pc", out_pc, 32'h100);
    tick();
    check("consume.valid", out_valid, 1'b0);
    check("consume.rd_hold", rd, 5'd3);

    // addi x5,x0,-1 then sw x5,8(x2), back to back
    drive(1'b1, 32'hFFF00293, 32'h104);
    check("addi.in_ready", in_ready, 1'b1);
    tick();
    drive(1'b1, 32'h00512423, 32'h108);
    expect_dec("addi", 5'd0, 5'd0, 5'd5, 3'b101, 4'h0, 3'd1, 32'hFFFFFFFF, 1'b0);
    check("b2b.in_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    expect_dec("sw", 5'd2, 5'd5, 5'd0, 3'b110, 4'h0, 3'd2, 32'h8, 1'b0);
    check("sw.pc", out_pc, 32'h108);
    check("sw.in_ready", in_ready, 1'b1);

    // sub held under back-pressure while an add waits at the input
    decode_one(32'h40208233, 32'h200);
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h204);
    check("stall.in_ready", in_ready, 1'b0);
    expect_dec("sub", 5'd1, 5'd2, 5'd4, 3'b111, 4'h8, 3'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d.valid", i), out_valid, 1'b1);
      check($sformatf("stall%0d.alu", i), alu_ctrl, 4'h8);
      check($sformatf("stall%0d.pc", i), out_pc, 32'h200);
      check($sformatf("stall%0d.rd", i), rd, 5'd4);
      check($sformatf("stall%0d.in_ready", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("release.in_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("queued.valid", out_valid, 1'b1);
    check("queued.pc", out_pc, 32'h204);
    check("queued.rd", rd, 5'd3);
    check("queued.alu", alu_ctrl, 4'h0);
    tick();
    check("drain.valid", out_valid, 1'b0);

    // A flush in the same cycle as a load drops the load
    flush = 1'b1;
    drive(1'b1, 32'hFFF00293, 32'h300);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_load.valid", out_valid, 1'b0);
    check("flush_load.pc", out_pc, 32'h204);

    // A flush while the held instruction is stalled discards it
    decode_one(32'h40208233, 32'h400);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    check("flush_stall.valid", out_valid, 1'b0);

    // Format and immediate corner cases
    decode_one(32'h40315093, 32'h500);  // srai x1,x2,3
    expect_dec("srai", 5'd2, 5'd0, 5'd1, 3'b101, 4'hD, 3'd1, 32'h403, 1'b0);
    decode_one(32'hFFC0A303, 32'h504);  // lw x6,-4(x1)
    expect_dec("lw", 5'd1, 5'd0, 5'd6, 3'b101, 4'h0, 3'd1, 32'hFFFFFFFC, 1'b0);
    decode_one(32'hFE209CE3, 32'h508);  // bne x1,x2,-8
    expect_dec("bne", 5'd1, 5'd2, 5'd0, 3'b110, 4'h1, 3'd3, 32'hFFFFFFF8, 1'b0);
    decode_one(32'h123453B7, 32'h50C);  // lui x7,0x12345
    expect_dec("lui", 5'd0, 5'd0, 5'd7, 3'b001, 4'h0, 3'd4, 32'h12345000, 1'b0);
    decode_one(32'hFFFFF0EF, 32'h510);  // jal x1,-2
    expect_dec("jal", 5'd0, 5'd0, 5'd1, 3'b001, 4'h0, 3'd5, 32'hFFFFFFFE, 1'b0);
    decode_one(32'h0010006F, 32'h514);  // jal x0,2048
    expect_dec("jal_x0", 5'd0, 5'd0, 5'd0, 3'b000, 4'h0, 3'd5, 32'h00000800, 1'b0);
    decode_one(32'h00000073, 32'h518);  // ecall
    expect_dec("ecall", 5'd0, 5'd0, 5'd0, 3'b000, 4'h0, 3'd6, 32'h0, 1'b0);

    // Illegal encodings
    decode_one(32'h40311093, 32'h600);  // slli with funct7 0100000
    expect_dec("ill_slli", 5'd0, 5'd0, 5'd0, 3'b000, 4'h0, 3'd0, 32'h0, 1'b1);
    decode_one(32'h40209233, 32'h604);  // R funct7 0100000 funct3 001
    expect_dec("ill_r_alt", 5'd0, 5'd0, 5'd0, 3'b000, 4'h0, 3'd0, 32'h0, 1'b1);
    decode_one(32'h002081B0, 32'h608);  // inst[1:0] = 00
    expect_dec("ill_lsb", 5'd0, 5'd0, 5'd0, 3'b000, 4'h0, 3'd0, 32'h0, 1'b1);
    decode_one(32'h0000005B, 32'h60C);  // unmapped opcode
    expect_dec("ill_opc", 5'd0, 5'd0, 5'd0, 3'b000, 4'h0, 3'd0, 32'h0, 1'b1);
    check("ill_opc.pc", out_pc, 32'h60C);

    // mul and div: illegal without M, muldiv with M
    decode_one(32'h02208133, 32'h700);
    expect_dec("mul_m0", 5'd0, 5'd0, 5'd0, 3'b000, 4'h0, 3'd0, 32'h0, 1'b1);
    check("mul_m1.valid", m1_out_valid, 1'b1);
    check("mul_m1.muldiv", m1_muldiv, 1'b1);
    check("mul_m1.illegal", m1_illegal, 1'b0);
    check("mul_m1.regs", {m1_rs1, m1_rs2, m1_rd}, {5'd1, 5'd2, 5'd2});
    check("mul_m1.en", {m1_rs1_en, m1_rs2_en, m1_rd_we}, 3'b111);
    check("mul_m1.alu", m1_alu_ctrl, 4'h0);
    check("mul_m1.fmt", m1_fmt, 3'd0);
    check("mul_m1.imm", m1_imm, 32'h0);
    check("mul_m1.pc", m1_out_pc, 32'h700);
    check("mul_m1.in_ready", m1_in_ready, 1'b1);
    decode_one(32'h0220C133, 32'h704);  // div x2,x1,x2
    check("div_m0.illegal", illegal, 1'b1);
    check("div_m1.muldiv", m1_muldiv, 1'b1);
    check("div_m1.alu", m1_alu_ctrl, 4'h4);

    // An asynchronous reset during a stall clears everything before the next edge
    decode_one(32'h123453B7, 32'h800);
    out_ready = 1'b0;
    tick();
    check("pre_rst.valid", out_valid, 1'b1);
    check("pre_rst.imm", imm, 32'h12345000);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst.valid", out_valid, 1'b0);
    check("async_rst.in_ready", in_ready, 1'b1);
    check("async_rst.rd", rd, 5'd0);
    check("async_rst.rd_we", rd_we, 1'b0);
    check("async_rst.imm", imm, 32'h0);
    check("async_rst.pc", out_pc, 32'h0);
    check("async_rst.fmt", fmt, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst.valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
